// File: rtl/l2_ram_mp_pkg.sv
// Shared types and sizing helpers for the multi-port private L2 RAM.
// Low address bits select the bank, the remaining bits select the row.
package l2_ram_mp_pkg;

   localparam int unsigned IdxW = 8;

   typedef logic [IdxW-1:0] port_idx_t;
   typedef logic [IdxW-1:0] bank_idx_t;

   typedef struct packed {
      logic      valid;
      bank_idx_t bank_idx;
      logic      we;
   } resp_stage_t;

   function automatic int unsigned calc_aw(input int unsigned words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

   function automatic int unsigned calc_bw(input int unsigned banks);
      return $clog2(banks);
   endfunction

   function automatic int unsigned calc_row_w(input int unsigned words,
                                              input int unsigned banks);
      return calc_aw(words / banks);
   endfunction

endpackage

// File: rtl/l2_ram_rr_arb.sv
// Per-bank round-robin arbiter, one grant per cycle.
// Pointer marks the port with highest priority next cycle.
module l2_ram_rr_arb
   import l2_ram_mp_pkg::*;
#(
   parameter int unsigned NumPorts = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NumPorts-1:0] req_i,
   output logic [NumPorts-1:0] gnt_o,
   output port_idx_t           idx_o
);

   port_idx_t           ptr_q;
   logic [NumPorts-1:0] req_rot;
   logic                found;
   int                  win;

   assign req_rot = NumPorts'({req_i, req_i} >> ptr_q);

   // Pick the first requester at or after the pointer, wrapping.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      win   = 0;
      if (!rst_i) begin
         for (int k = 0; k < int'(NumPorts); k++) begin
            if (!found && req_rot[k]) begin
               found = 1'b1;
               win   = int'(ptr_q) + k;
               if (win >= int'(NumPorts)) win = win - int'(NumPorts);
            end
         end
         if (found) begin
            idx_o = port_idx_t'(win);
            gnt_o = NumPorts'(1) << win;
         end
      end
   end

   // Move priority past the winner; hold when the bank is idle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else if (found) begin
         ptr_q <= (idx_o == port_idx_t'(NumPorts - 1)) ? '0 : idx_o + 1'b1;
      end
   end

endmodule

// File: rtl/l2_sram_private_macro_wrap.sv
// Wrapper around one private L2 macro bank.
// Maps onto the generic SRAM model when no hard macro is present.
module l2_sram_private_macro_wrap #(
   parameter int unsigned  NumWords  = 2048,
   parameter int unsigned  DataWidth = 32,
   localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
   localparam int unsigned BeW       = DataWidth / 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_i,
   input  logic                 we_i,
   input  logic [AddrWidth-1:0] addr_i,
   input  logic [DataWidth-1:0] wdata_i,
   input  logic [BeW-1:0]       be_i,
   output logic [DataWidth-1:0] rdata_o
);

   tc_sram #(
      .NumWords  (NumWords),
      .DataWidth (DataWidth),
      .ByteWidth (8),
      .NumPorts  (1),
      .Latency   (1)
   ) i_macro (
      .clk_i   (clk_i),
      .rst_ni  (~rst_i),
      .req_i   (req_i),
      .we_i    (we_i),
      .addr_i  (addr_i),
      .wdata_i (wdata_i),
      .be_i    (be_i),
      .rdata_o (rdata_o)
   );

endmodule

// File: rtl/tc_sram.sv
// Generic single-cycle SRAM model with byte-masked writes.
// Read data is registered and held until the next read.
module tc_sram #(
   parameter int unsigned  NumWords  = 1024,
   parameter int unsigned  DataWidth = 32,
   parameter int unsigned  ByteWidth = 8,
   parameter int unsigned  NumPorts  = 1,
   parameter int unsigned  Latency   = 1,
   localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
   localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NumPorts-1:0]                 req_i,
   input  logic [NumPorts-1:0]                 we_i,
   input  logic [NumPorts-1:0][AddrWidth-1:0]  addr_i,
   input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
   input  logic [NumPorts-1:0][BeWidth-1:0]    be_i,
   output logic [NumPorts-1:0][DataWidth-1:0]  rdata_o
);

   logic [DataWidth-1:0] mem_q [NumWords];

   if (Latency != 1) begin : g_lat_chk
      $error("tc_sram model supports Latency=1 only");
   end

   // Write only the enabled bytes; contents are never reset.
   always_ff @(posedge clk_i) begin
      for (int p = 0; p < int'(NumPorts); p++) begin
         if (req_i[p] && we_i[p]) begin
            for (int i = 0; i < int'(BeWidth); i++) begin
               if (be_i[p][i]) begin
                  mem_q[addr_i[p]][i*ByteWidth +: ByteWidth] <=
                     wdata_i[p][i*ByteWidth +: ByteWidth];
               end
            end
         end
      end
   end

   // Registered read port.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_o <= '0;
      end else begin
         for (int p = 0; p < int'(NumPorts); p++) begin
            if (req_i[p] && !we_i[p]) rdata_o[p] <= mem_q[addr_i[p]];
         end
      end
   end

endmodule

// File: rtl/l2_ram_bank_private_mp.sv
// Multi-port private L2 RAM over word-interleaved banks.
// Fixed-latency responses, in order per port, no backpressure.
module l2_ram_bank_private_mp
   import l2_ram_mp_pkg::*;
#(
   parameter int unsigned  NumPorts    = 2,
   parameter int unsigned  NumBanks    = 4,
   parameter int unsigned  NumWords    = 8192,
   parameter int unsigned  DataWidth   = 32,
   parameter int unsigned  ReadLatency = 1,
   parameter bit           BehavMem    = 1'b1,
   localparam int unsigned AW          = calc_aw(NumWords),
   localparam int unsigned BeW         = DataWidth / 8
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [NumPorts-1:0]                req_i,
   output logic [NumPorts-1:0]                gnt_o,
   input  logic [NumPorts-1:0]                we_i,
   input  logic [NumPorts-1:0][AW-1:0]        addr_i,
   input  logic [NumPorts-1:0][DataWidth-1:0] wdata_i,
   input  logic [NumPorts-1:0][BeW-1:0]       be_i,
   output logic [NumPorts-1:0]                rvalid_o,
   output logic [NumPorts-1:0][DataWidth-1:0] rdata_o
);

   localparam int unsigned BW        = calc_bw(NumBanks);
   localparam int unsigned RowW      = calc_row_w(NumWords, NumBanks);
   localparam int unsigned BankWords = NumWords / NumBanks;

   if (NumWords % NumBanks != 0) begin : g_chk_words
      $error("NumWords must be a multiple of NumBanks");
   end
   if (NumBanks == 0 || (NumBanks & (NumBanks - 1)) != 0) begin : g_chk_banks
      $error("NumBanks must be a power of 2");
   end
   if (ReadLatency != 1 && ReadLatency != 2) begin : g_chk_lat
      $error("ReadLatency must be 1 or 2");
   end
   if (DataWidth % 8 != 0) begin : g_chk_dw
      $error("DataWidth must be a multiple of 8");
   end
   if (NumPorts == 0 || NumPorts > 256) begin : g_chk_ports
      $error("NumPorts must be in 1..256");
   end

   bank_idx_t   [NumPorts-1:0]                bank_sel;
   logic        [NumPorts-1:0][RowW-1:0]      row;
   logic        [NumBanks-1:0][NumPorts-1:0]  bank_gnt;
   logic        [NumBanks-1:0][DataWidth-1:0] bank_rdata;
   resp_stage_t [NumPorts-1:0]                s0_q;
   logic        [NumPorts-1:0][DataWidth-1:0] rd0;

   for (genvar p = 0; p < NumPorts; p++) begin : g_split
      assign bank_sel[p] = bank_idx_t'(addr_i[p] & AW'(NumBanks - 1));
      assign row[p]      = RowW'(addr_i[p] >> BW);
   end

   for (genvar b = 0; b < NumBanks; b++) begin : g_bank
      logic [NumPorts-1:0]  breq;
      port_idx_t            widx;
      logic                 mreq;
      logic                 mwe;
      logic [RowW-1:0]      maddr;
      logic [DataWidth-1:0] mwdata;
      logic [BeW-1:0]       mbe;

      // Requests whose address decodes to this bank.
      always_comb begin
         breq = '0;
         for (int p = 0; p < int'(NumPorts); p++) begin
            breq[p] = req_i[p] && (bank_sel[p] == bank_idx_t'(b));
         end
      end

      l2_ram_rr_arb #(
         .NumPorts (NumPorts)
      ) i_arb (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .req_i (breq),
         .gnt_o (bank_gnt[b]),
         .idx_o (widx)
      );

      // Steer the winning port onto the bank.
      always_comb begin
         mreq   = |bank_gnt[b];
         mwe    = 1'b0;
         maddr  = '0;
         mwdata = '0;
         mbe    = '0;
         for (int p = 0; p < int'(NumPorts); p++) begin
            if (mreq && port_idx_t'(p) == widx) begin
               mwe    = we_i[p];
               maddr  = row[p];
               mwdata = wdata_i[p];
               mbe    = be_i[p];
            end
         end
      end

      if (BehavMem) begin : g_behav
         tc_sram #(
            .NumWords  (BankWords),
            .DataWidth (DataWidth),
            .ByteWidth (8),
            .NumPorts  (1),
            .Latency   (1)
         ) i_sram (
            .clk_i   (clk_i),
            .rst_ni  (~rst_i),
            .req_i   (mreq),
            .we_i    (mwe),
            .addr_i  (maddr),
            .wdata_i (mwdata),
            .be_i    (mbe),
            .rdata_o (bank_rdata[b])
         );
      end else begin : g_macro
         l2_sram_private_macro_wrap #(
            .NumWords  (BankWords),
            .DataWidth (DataWidth)
         ) i_sram (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .req_i   (mreq),
            .we_i    (mwe),
            .addr_i  (maddr),
            .wdata_i (mwdata),
            .be_i    (mbe),
            .rdata_o (bank_rdata[b])
         );
      end
   end

   // A port targets one bank, so OR-ing bank grants never double-grants.
   always_comb begin
      gnt_o = '0;
      for (int b = 0; b < int'(NumBanks); b++) gnt_o = gnt_o | bank_gnt[b];
   end

   // First response stage: what each port got accepted this edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s0_q <= '0;
      end else begin
         for (int p = 0; p < int'(NumPorts); p++) begin
            s0_q[p] <= '{valid:    req_i[p] & gnt_o[p],
                         bank_idx: bank_sel[p],
                         we:       we_i[p]};
         end
      end
   end

   // Pick the raw bank output; writes and idle slots return zero.
   always_comb begin
      rd0 = '0;
      for (int p = 0; p < int'(NumPorts); p++) begin
         for (int b = 0; b < int'(NumBanks); b++) begin
            if (s0_q[p].valid && !s0_q[p].we &&
                s0_q[p].bank_idx == bank_idx_t'(b)) begin
               rd0[p] = bank_rdata[b];
            end
         end
      end
   end

   if (ReadLatency == 2) begin : g_lat2
      logic [NumPorts-1:0]                v1_q;
      logic [NumPorts-1:0][DataWidth-1:0] rd1_q;

      // Extra output register stage for timing.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            v1_q  <= '0;
            rd1_q <= '0;
         end else begin
            for (int p = 0; p < int'(NumPorts); p++) begin
               v1_q[p]  <= s0_q[p].valid;
               rd1_q[p] <= rd0[p];
            end
         end
      end

      assign rvalid_o = v1_q;
      assign rdata_o  = rd1_q;
   end else begin : g_lat1
      for (genvar p = 0; p < NumPorts; p++) begin : g_v
         assign rvalid_o[p] = s0_q[p].valid;
      end
      assign rdata_o = rd0;
   end

endmodule

// File: tb/tb_l2_ram_bank_private_mp.sv
// Bench for l2_ram_bank_private_mp: directed cases plus random traffic
// checked every cycle against a schedule-based reference model.
module tb_l2_ram_bank_private_mp;

   localparam int NP   = 2;
   localparam int NB   = 4;
   localparam int NW   = 8192;
   localparam int DW   = 32;
   localparam int RL   = 2;
   localparam int AW   = 13;
   localparam int BEW  = 4;
   localparam int MA   = 64;
   localparam int MAXC = 4096;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NP-1:0]          req, we, gnt, rvalid;
   logic [NP-1:0][AW-1:0]  addr;
   logic [NP-1:0][DW-1:0]  wdata, rdata;
   logic [NP-1:0][BEW-1:0] be;

   always #5 clk = ~clk;

   l2_ram_bank_private_mp #(
      .NumPorts    (NP),
      .NumBanks    (NB),
      .NumWords    (NW),
      .DataWidth   (DW),
      .ReadLatency (RL),
      .BehavMem    (1'b1)
   ) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .req_i    (req),
      .gnt_o    (gnt),
      .we_i     (we),
      .addr_i   (addr),
      .wdata_i  (wdata),
      .be_i     (be),
      .rvalid_o (rvalid),
      .rdata_o  (rdata)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int dut_rv = 0;
   logic [DW-1:0] mem [MA];
   bit            known [MA];
   int            ptr [NB];
   bit            sv [NP][MAXC];
   logic [DW-1:0] sd [NP][MAXC];
   bit            sk [NP][MAXC];
   logic [DW-1:0] last_rd [NP];
   int            nresp [NP];

   function automatic void chk(input string nm, input logic [63:0] act,
                               input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endfunction

   function automatic logic [NP-1:0] model_gnt();
      logic [NP-1:0] g;
      g = '0;
      if (rst) return g;
      for (int b = 0; b < NB; b++) begin
         for (int k = 0; k < NP; k++) begin
            int c;
            c = (ptr[b] + k) % NP;
            if (req[c] && (int'(addr[c]) % NB) == b) begin
               g[c] = 1'b1;
               break;
            end
         end
      end
      return g;
   endfunction

   task automatic tick(output logic [NP-1:0] acc, output logic [NP-1:0] g);
      logic [NP-1:0] eg;
      @(negedge clk);
      eg = model_gnt();
      g  = gnt;
      chk("gnt", gnt, eg);
      acc = req & eg;
      @(posedge clk);
      cyc++;
      if (rst) begin
         for (int b = 0; b < NB; b++) ptr[b] = 0;
         for (int p = 0; p < NP; p++)
            for (int c = cyc; c < MAXC; c++) sv[p][c] = 1'b0;
      end else begin
         for (int p = 0; p < NP; p++) begin
            if (acc[p]) begin
               int a, bk, due;
               a   = int'(addr[p]);
               bk  = a % NB;
               due = cyc + RL - 1;
               ptr[bk] = (p + 1) % NP;
               sv[p][due] = 1'b1;
               if (we[p]) begin
                  sd[p][due] = '0;
                  sk[p][due] = 1'b1;
                  for (int i = 0; i < BEW; i++)
                     if (be[p][i]) mem[a][i*8 +: 8] = wdata[p][i*8 +: 8];
                  if (be[p] == 4'hF) known[a] = 1'b1;
               end else begin
                  sd[p][due] = mem[a];
                  sk[p][due] = known[a];
               end
            end
         end
      end
      #1;
      for (int p = 0; p < NP; p++) begin
         if (rvalid[p] === 1'b1) dut_rv++;
         chk("rvalid", rvalid[p], sv[p][cyc]);
         if (sv[p][cyc]) begin
            nresp[p]++;
            last_rd[p] = rdata[p];
            if (sk[p][cyc]) chk("rdata", rdata[p], sd[p][cyc]);
         end else begin
            chk("rdata_idle", rdata[p], '0);
         end
      end
   endtask

   task automatic idle(input int n);
      logic [NP-1:0] acc, g;
      for (int i = 0; i < n; i++) tick(acc, g);
   endtask

   task automatic xact(input int p, input logic w, input int a,
                       input logic [DW-1:0] d, input logic [BEW-1:0] m);
      logic [NP-1:0] acc, g;
      bit done;
      done = 1'b0;
      req[p] = 1'b1; we[p] = w; addr[p] = AW'(a);
      wdata[p] = d; be[p] = m;
      for (int i = 0; i < 8 && !done; i++) begin
         tick(acc, g);
         done = acc[p];
      end
      req[p] = 1'b0;
      chk("xact_granted", done, 1);
   endtask

   initial begin
      logic [NP-1:0] acc, g, accp;
      logic [NP-1:0] gs [4];
      int n0, n1, rv0;
      for (int b = 0; b < NB; b++) ptr[b] = 0;
      for (int i = 0; i < MA; i++) begin mem[i] = '0; known[i] = 1'b0; end
      for (int p = 0; p < NP; p++) begin nresp[p] = 0; last_rd[p] = '0; end
      req = '0; we = '0; addr = '0; wdata = '0; be = '0;

      // Reset held with both ports requesting bank 0.
      rst = 1'b1; req = '1; addr[0] = AW'(0); addr[1] = AW'(4);
      for (int i = 0; i < 3; i++) begin
         tick(acc, g);
         chk("rst_gnt", g, 0);
         chk("rst_rvalid", rvalid, 0);
      end
      rst = 1'b0;
      tick(acc, g);
      chk("first_gnt_p0", g, 2'b01);
      req = '0;
      idle(RL + 1);

      // Preload addresses through port 1 (leaves all pointers at 0).
      for (int a = 0; a < 32; a++) xact(1, 1'b1, a, $urandom, 4'hF);
      idle(RL + 1);

      // Write then read-after-write.
      xact(0, 1'b1, 16, 32'hDEADBEEF, 4'hF);
      xact(0, 1'b0, 16, 32'h0, 4'h0);
      idle(RL + 1);
      chk("raw_data", last_rd[0], 32'hDEADBEEF);

      // Byte enables.
      xact(0, 1'b1, 5, 32'h11223344, 4'hF);
      xact(0, 1'b1, 5, 32'hAABBCCDD, 4'b0101);
      xact(0, 1'b0, 5, 32'h0, 4'h0);
      idle(RL + 1);
      chk("be_data", last_rd[0], 32'h11BB33DD);
      chk("model_be", mem[5], 32'h11BB33DD);

      // Bank conflict on bank 2.
      n0 = nresp[0]; n1 = nresp[1];
      req = 2'b11; we = '0; addr[0] = AW'(2); addr[1] = AW'(6);
      for (int i = 0; i < 4; i++) begin tick(acc, g); gs[i] = g; end
      req = '0;
      idle(RL + 1);
      chk("conflict_g0", gs[0], 2'b01);
      chk("conflict_g1", gs[1], 2'b10);
      chk("conflict_g2", gs[2], 2'b01);
      chk("conflict_g3", gs[3], 2'b10);
      chk("conflict_n0", nresp[0] - n0, 2);
      chk("conflict_n1", nresp[1] - n1, 2);

      // Parallel banks.
      req = 2'b11; we = '0; addr[0] = AW'(0); addr[1] = AW'(1);
      tick(acc, g);
      chk("parallel_gnt", g, 2'b11);
      req = '0;
      idle(RL + 1);

      // Reset while a read is in flight.
      xact(0, 1'b1, 7, 32'hCAFEF00D, 4'hF);
      idle(RL + 1);
      rv0 = dut_rv;
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = AW'(7);
      tick(acc, g);
      chk("flight_accept", acc, 2'b01);
      req = '0; rst = 1'b1;
      tick(acc, g);
      rst = 1'b0;
      idle(RL + 2);
      chk("flight_dropped", dut_rv - rv0, 0);
      xact(0, 1'b0, 7, 32'h0, 4'h0);
      idle(RL + 1);
      chk("persist_data", last_rd[0], 32'hCAFEF00D);

      // Random traffic; ports hold a request until it is accepted.
      accp = '0;
      for (int i = 0; i < 400; i++) begin
         for (int p = 0; p < NP; p++) begin
            if (!req[p] || accp[p]) begin
               req[p]   = ($urandom_range(0, 3) != 0);
               we[p]    = 1'($urandom_range(0, 1));
               addr[p]  = AW'($urandom_range(0, 31));
               wdata[p] = $urandom;
               be[p]    = BEW'($urandom_range(0, 15));
            end
         end
         rst = ($urandom_range(0, 99) == 0);
         tick(accp, g);
      end
      req = '0; rst = 1'b0;
      idle(RL + 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
